// File: rtl/milano_pkg.sv
// Shared types for the milano execute stage: operator encoding, EX FSM states, helpers.
package milano_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_DIV  = 4'd10,
      ALU_DIVU = 4'd11,
      ALU_REM  = 4'd12,
      ALU_REMU = 4'd13
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_FIN  = 2'd2
   } ex_state_e;

   function automatic logic is_div_op(alu_op_e op);
      return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
   endfunction

endpackage

// File: rtl/ex_div_core.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock, XLEN iterations.
module ex_div_core #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            done_o,
   output logic [XLEN-1:0] quot_o,
   output logic [XLEN-1:0] rem_o
);

   localparam int CW = $clog2(XLEN);

   logic [XLEN-1:0] quot_q, rem_q, dvsr_q;
   logic [CW-1:0]   cnt_q;
   logic            busy_q;
   logic [XLEN:0]   rem_sh, diff;

   // Dividend bits shift out of the quotient register into the partial remainder.
   assign rem_sh = {rem_q, quot_q[XLEN-1]};
   assign diff   = rem_sh - {1'b0, dvsr_q};

   // High on the edge that performs the final iteration.
   assign done_o = busy_q && (cnt_q == CW'(XLEN-1));
   assign quot_o = quot_q;
   assign rem_o  = rem_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         quot_q <= '0;
         rem_q  <= '0;
         dvsr_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (flush_i) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start_i) begin
         quot_q <= dividend_i;
         rem_q  <= '0;
         dvsr_q <= divisor_i;
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         if (!diff[XLEN]) begin
            rem_q  <= diff[XLEN-1:0];
            quot_q <= {quot_q[XLEN-2:0], 1'b1};
         end else begin
            rem_q  <= rem_sh[XLEN-1:0];
            quot_q <= {quot_q[XLEN-2:0], 1'b0};
         end
         cnt_q <= cnt_q + 1'b1;
         if (done_o) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative divider that stalls ID via ready_o.
import milano_pkg::*;

module ex_stage #(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [3:0]      alu_op_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [4:0]      rd_addr_i,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_addr_o,
   output logic            wb_valid_o
);

   alu_op_e         op;
   ex_state_e       state_q, state_d;
   logic            accept, alu_fire, div_latch, div_start, fin_fire;
   logic            op_signed, op_rem, a_neg, b_neg, div_zero, div_ovf, fast;
   logic [XLEN-1:0] a_abs, b_abs, fast_res, alu_res, fin_mag, fin_res;
   logic [4:0]      shamt;
   logic            fast_q, neg_q, is_rem_q;
   logic [XLEN-1:0] fast_res_q;
   logic [4:0]      rd_q;
   logic            core_done;
   logic [XLEN-1:0] core_quot, core_rem;

   assign op      = alu_op_e'(alu_op_i);
   assign shamt   = rs2_data_i[4:0];
   assign ready_o = (state_q == ST_IDLE);
   assign accept  = valid_i && ready_o && !flush_i;

   always_comb begin
      alu_res = '0;
      case (op)
         ALU_ADD:  alu_res = rs1_data_i + rs2_data_i;
         ALU_SUB:  alu_res = rs1_data_i - rs2_data_i;
         ALU_AND:  alu_res = rs1_data_i & rs2_data_i;
         ALU_OR:   alu_res = rs1_data_i | rs2_data_i;
         ALU_XOR:  alu_res = rs1_data_i ^ rs2_data_i;
         ALU_SLL:  alu_res = rs1_data_i << shamt;
         ALU_SRL:  alu_res = rs1_data_i >> shamt;
         ALU_SRA:  alu_res = $signed(rs1_data_i) >>> shamt;
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_data_i) < $signed(rs2_data_i)};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1_data_i < rs2_data_i};
         default:  alu_res = '0;
      endcase
   end

   // Divider operands go in as magnitudes; signs are reapplied in FIN.
   assign op_signed = (op == ALU_DIV) || (op == ALU_REM);
   assign op_rem    = (op == ALU_REM) || (op == ALU_REMU);
   assign a_neg     = op_signed && rs1_data_i[XLEN-1];
   assign b_neg     = op_signed && rs2_data_i[XLEN-1];
   assign a_abs     = a_neg ? -rs1_data_i : rs1_data_i;
   assign b_abs     = b_neg ? -rs2_data_i : rs2_data_i;
   assign div_zero  = (rs2_data_i == '0);
   assign div_ovf   = op_signed && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);
   assign fast      = div_zero || div_ovf;

   always_comb begin
      fast_res = '0;
      if (div_zero)     fast_res = op_rem ? rs1_data_i : '1;
      else if (div_ovf) fast_res = op_rem ? '0 : rs1_data_i;
   end

   assign fin_mag = is_rem_q ? core_rem : core_quot;
   assign fin_res = fast_q ? fast_res_q : (neg_q ? -fin_mag : fin_mag);

   always_comb begin
      state_d   = state_q;
      alu_fire  = 1'b0;
      div_latch = 1'b0;
      div_start = 1'b0;
      fin_fire  = 1'b0;
      if (flush_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (accept) begin
               if (is_div_op(op)) begin
                  div_latch = 1'b1;
                  div_start = !fast;
                  state_d   = fast ? ST_FIN : ST_DIV;
               end else begin
                  alu_fire = 1'b1;
               end
            end
            ST_DIV:  if (core_done) state_d = ST_FIN;
            ST_FIN:  begin
               fin_fire = 1'b1;
               state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         result_o   <= '0;
         rd_addr_o  <= '0;
         wb_valid_o <= 1'b0;
         fast_q     <= 1'b0;
         neg_q      <= 1'b0;
         is_rem_q   <= 1'b0;
         fast_res_q <= '0;
         rd_q       <= '0;
      end else begin
         state_q    <= state_d;
         wb_valid_o <= alu_fire || fin_fire;
         if (alu_fire) begin
            result_o  <= alu_res;
            rd_addr_o <= rd_addr_i;
         end
         if (fin_fire) begin
            result_o  <= fin_res;
            rd_addr_o <= rd_q;
         end
         if (div_latch) begin
            fast_q     <= fast;
            neg_q      <= op_rem ? a_neg : (a_neg ^ b_neg);
            is_rem_q   <= op_rem;
            fast_res_q <= fast_res;
            rd_q       <= rd_addr_i;
         end
      end
   end

   ex_div_core #(.XLEN(XLEN)) u_div (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (div_start),
      .flush_i    (flush_i),
      .dividend_i (a_abs),
      .divisor_i  (b_abs),
      .done_o     (core_done),
      .quot_o     (core_quot),
      .rem_o      (core_rem)
   );

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, divider latency/corners, flush and reset behaviour.
import milano_pkg::*;

module tb_ex_stage;

   logic        clk_i = 1'b0;
   logic        rst_ni, flush_i, valid_i;
   logic        ready_o, wb_valid_o;
   logic [3:0]  alu_op_i;
   logic [31:0] rs1_data_i, rs2_data_i, result_o;
   logic [4:0]  rd_addr_i, rd_addr_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   ex_stage #(.XLEN(32)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .alu_op_i   (alu_op_i),
      .rs1_data_i (rs1_data_i),
      .rs2_data_i (rs2_data_i),
      .rd_addr_i  (rd_addr_i),
      .result_o   (result_o),
      .rd_addr_o  (rd_addr_o),
      .wb_valid_o (wb_valid_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      alu_op_i   = op;
      rs1_data_i = a;
      rs2_data_i = b;
      rd_addr_i  = rd;
      valid_i    = 1'b1;
   endtask

   // valid_i stays high through the stall; it drops in the completion cycle.
   task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_lat);
      int n;
      logic rdy_low;
      drive(op, a, b, rd);
      cyc();
      n       = 0;
      rdy_low = 1'b1;
      while (!wb_valid_o && n < 100) begin
         if (ready_o) rdy_low = 1'b0;
         cyc();
         n++;
      end
      valid_i = 1'b0;
      chk({tag, " latency"}, 32'(n), 32'(exp_lat));
      chk({tag, " result"}, result_o, exp);
      chk({tag, " rd"}, 32'(rd_addr_o), 32'(rd));
      chk({tag, " ready low in stall"}, 32'(rdy_low), 32'd1);
      cyc();
      chk({tag, " wb pulse"}, 32'(wb_valid_o), 32'd0);
      chk({tag, " ready after"}, 32'(ready_o), 32'd1);
   endtask

   initial begin
      int seen;
      rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
      alu_op_i = '0; rs1_data_i = '0; rs2_data_i = '0; rd_addr_i = '0;
      cyc(); cyc();
      chk("reset result", result_o, 32'd0);
      chk("reset wb", 32'(wb_valid_o), 32'd0);
      chk("reset ready", 32'(ready_o), 32'd1);
      rst_ni = 1'b1;
      cyc();

      // 1: reset mid-divide
      drive(ALU_ADD, 32'd5, 32'd7, 5'd3);
      cyc();
      chk("add wb", 32'(wb_valid_o), 32'd1);
      chk("add res", result_o, 32'd12);
      chk("add rd", 32'(rd_addr_o), 32'd3);
      drive(ALU_DIVU, 32'd100, 32'd7, 5'd4);
      cyc();
      valid_i = 1'b0;
      chk("div ready low", 32'(ready_o), 32'd0);
      cyc(); cyc(); cyc();
      rst_ni = 1'b0;
      #1;
      chk("midrst result", result_o, 32'd0);
      chk("midrst rd", 32'(rd_addr_o), 32'd0);
      chk("midrst wb", 32'(wb_valid_o), 32'd0);
      chk("midrst ready", 32'(ready_o), 32'd1);
      cyc();
      rst_ni = 1'b1;
      drive(ALU_ADD, 32'd5, 32'd7, 5'd1);
      cyc();
      valid_i = 1'b0;
      chk("post-rst add wb", 32'(wb_valid_o), 32'd1);
      chk("post-rst add res", result_o, 32'd12);
      cyc();
      chk("post-rst add pulse", 32'(wb_valid_o), 32'd0);
      chk("post-rst hold res", result_o, 32'd12);

      // 2: back-to-back ALU
      drive(ALU_SUB, 32'd0, 32'd1, 5'd5);
      cyc();
      chk("sub res", result_o, 32'hFFFF_FFFF);
      chk("sub wb", 32'(wb_valid_o), 32'd1);
      drive(ALU_SRA, 32'h8000_0000, 32'd4, 5'd6);
      cyc();
      chk("sra res", result_o, 32'hF800_0000);
      chk("sra wb", 32'(wb_valid_o), 32'd1);
      drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd7);
      cyc();
      chk("slt res", result_o, 32'd1);
      chk("slt wb", 32'(wb_valid_o), 32'd1);
      drive(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd8);
      cyc();
      chk("sltu res", result_o, 32'd0);
      chk("sltu wb", 32'(wb_valid_o), 32'd1);
      chk("sltu rd", 32'(rd_addr_o), 32'd8);
      drive(ALU_SRL, 32'h8000_0000, 32'd4, 5'd0);
      cyc();
      chk("srl res", result_o, 32'h0800_0000);
      chk("x0 wb", 32'(wb_valid_o), 32'd1);
      drive(ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9);
      cyc();
      valid_i = 1'b0;
      chk("xor res", result_o, 32'h0FF0_0FF0);
      cyc();
      chk("alu idle wb", 32'(wb_valid_o), 32'd0);

      // 3: iterative divides
      run_div("div -7/2",  ALU_DIV,  32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33);
      run_div("rem -7%2",  ALU_REM,  32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33);
      run_div("divu 100/7", ALU_DIVU, 32'd100, 32'd7, 5'd12, 32'd14, 33);
      run_div("remu 100%7", ALU_REMU, 32'd100, 32'd7, 5'd13, 32'd2, 33);
      run_div("div 7/-2",  ALU_DIV,  32'd7, 32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, 33);

      // 4: fast-path corners
      run_div("divu 9/0",  ALU_DIVU, 32'd9, 32'd0, 5'd15, 32'hFFFF_FFFF, 1);
      run_div("rem 9%0",   ALU_REM,  32'd9, 32'd0, 5'd16, 32'd9, 1);
      run_div("div ovf",   ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1);
      run_div("rem ovf",   ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, 1);

      // 5: flush mid-divide
      drive(ALU_DIVU, 32'd100, 32'd7, 5'd19);
      cyc();
      valid_i = 1'b0;
      repeat (9) cyc();
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      chk("flush ready", 32'(ready_o), 32'd1);
      chk("flush keeps res", result_o, 32'd0);
      seen = 0;
      repeat (40) begin
         if (wb_valid_o) seen++;
         cyc();
      end
      chk("flush no wb", 32'(seen), 32'd0);
      drive(ALU_ADD, 32'd1, 32'd2, 5'd20);
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      chk("flush blocks accept", 32'(wb_valid_o), 32'd0);
      cyc();
      valid_i = 1'b0;
      chk("post-flush add res", result_o, 32'd3);
      chk("post-flush add wb", 32'(wb_valid_o), 32'd1);

      // 6: new op accepted in the divide completion cycle
      drive(ALU_DIVU, 32'd100, 32'd7, 5'd21);
      cyc();
      valid_i = 1'b0;
      seen = 0;
      while (!wb_valid_o && seen < 100) begin
         cyc();
         seen++;
      end
      chk("overlap div latency", 32'(seen), 32'd33);
      chk("overlap div res", result_o, 32'd14);
      chk("overlap ready", 32'(ready_o), 32'd1);
      drive(ALU_ADD, 32'd20, 32'd22, 5'd22);
      cyc();
      valid_i = 1'b0;
      chk("overlap add wb", 32'(wb_valid_o), 32'd1);
      chk("overlap add res", result_o, 32'd42);
      chk("overlap add rd", 32'(rd_addr_o), 32'd22);
      cyc();
      chk("overlap end wb", 32'(wb_valid_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
